ssp_ctrl: RTL and testbench

Owns the shadow stack pointer (SSP) for the backward-edge CFI extension. It supplies the speculative SSP to the ALU's ssp_i and captures the ALU's SSPINC result (ssp_o) into a small in-order pending queue tagged by scoreboard trans_id. Each entry becomes architectural when the commit stage retires that trans_id. Flushes discard speculative entries. CSR writes load the architectural value directly.

---
 rtl/ssp_ctrl_pkg.sv | 25 ++
 rtl/ssp_ctrl.sv | 139 +++++++++++++
 tb/tb_ssp_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ssp_ctrl_pkg.sv
// Shared types and constants for the shadow stack pointer controller.
package ssp_ctrl_pkg;

   localparam int XLEN          = 64;
   localparam int TRANS_ID_BITS = 3;

   // Low bits of every captured SSP are cleared to keep it XLEN-aligned.
   localparam int SSP_ALIGN_BITS = $clog2(XLEN / 8);

   typedef logic [XLEN-1:0] xlen_t;

   typedef struct packed {
      logic [TRANS_ID_BITS-1:0] trans_id;
      xlen_t                    ssp;
   } ssp_entry_t;

   // Clear the alignment bits of a candidate SSP value.
   function automatic xlen_t ssp_align(input xlen_t value);
      xlen_t mask;
      mask = '1;
      mask[SSP_ALIGN_BITS-1:0] = '0;
      return value & mask;
   endfunction

endpackage

// File: rtl/ssp_ctrl.sv
// Shadow stack pointer owner: speculative SSP for the ALU, an in-order
// pending queue of SSPINC results tagged by trans_id, and the committed SSP.
module ssp_ctrl
   import ssp_ctrl_pkg::*;
#(
   parameter int NR_PENDING = 4,
   parameter int TRANS_ID_W = TRANS_ID_BITS
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            flush_i,
   input  logic                            xBCFIE_i,
   input  logic                            upd_valid_i,
   input  logic [TRANS_ID_W-1:0]           upd_trans_id_i,
   input  logic [XLEN-1:0]                 upd_ssp_i,
   output logic                            upd_ready_o,
   input  logic                            commit_valid_i,
   input  logic [TRANS_ID_W-1:0]           commit_trans_id_i,
   output logic                            commit_err_o,
   input  logic                            csr_we_i,
   input  logic [XLEN-1:0]                 csr_wdata_i,
   output logic [XLEN-1:0]                 ssp_o,
   output logic [XLEN-1:0]                 ssp_arch_o,
   output logic [$clog2(NR_PENDING+1)-1:0] pending_o
);

   localparam int PTR_W = $clog2(NR_PENDING);
   localparam int CNT_W = $clog2(NR_PENDING + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NR_PENDING);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // Queue storage, one trans_id/ssp pair per slot.
   logic [TRANS_ID_W-1:0] tag_mem [NR_PENDING];
   xlen_t                 ssp_mem [NR_PENDING];

   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic [CNT_W-1:0] count_reg, count_next;
   xlen_t            arch_reg, arch_next;
   logic             err_reg, err_next;

   logic             not_empty;
   logic             commit_match;
   logic             commit_fire;
   logic             enq_fire;
   logic [PTR_W-1:0] youngest_ptr;

   assign not_empty    = (count_reg != '0);
   assign upd_ready_o  = (count_reg != CNT_FULL);
   assign youngest_ptr = tail_reg - PTR_ONE;

   // A commit only matches an entry that is already stored at the head;
   // a same-cycle enqueue into an empty queue is therefore not visible.
   assign commit_match = commit_valid_i && not_empty &&
                         (tag_mem[head_reg] == commit_trans_id_i);
   assign commit_fire  = commit_match && !csr_we_i;
   assign enq_fire     = upd_valid_i && upd_ready_o && xBCFIE_i &&
                         !flush_i && !csr_we_i;

   // Next-state for pointers, count, committed SSP and the error pulse.
   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      arch_next  = arch_reg;
      err_next   = 1'b0;

      if (csr_we_i) begin
         // Serialising write: no SSPINC can be in flight, so just reload.
         arch_next  = ssp_align(csr_wdata_i);
         head_next  = tail_reg;
         count_next = '0;
      end else begin
         err_next = commit_valid_i && !commit_match;

         if (commit_fire) begin
            arch_next = ssp_mem[head_reg];
            head_next = head_reg + PTR_ONE;
         end

         if (enq_fire) begin
            tail_next = tail_reg + PTR_ONE;
         end

         case ({enq_fire, commit_fire})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
         endcase

         // The commit above is older than the flush and is kept; everything
         // younger is discarded (the enqueue was already suppressed).
         if (flush_i) begin
            head_next  = tail_reg;
            count_next = '0;
         end
      end
   end

   // Control state with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         arch_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
         arch_reg  <= arch_next;
         err_reg   <= err_next;
      end
   end

   // Per-slot write port; contents need no reset because count gates them.
   for (genvar gi = 0; gi < NR_PENDING; gi++) begin : g_slot
      always_ff @(posedge clk_i) begin
         if (enq_fire && (tail_reg == PTR_W'(gi))) begin
            tag_mem[gi] <= upd_trans_id_i;
            ssp_mem[gi] <= ssp_align(upd_ssp_i);
         end
      end
   end

   // Speculative SSP: youngest pending value, else committed value.
   always_comb begin
      ssp_o = '0;
      if (xBCFIE_i) begin
         ssp_o = not_empty ? ssp_mem[youngest_ptr] : arch_reg;
      end
   end

   assign ssp_arch_o   = arch_reg;
   assign commit_err_o = err_reg;
   assign pending_o    = count_reg;

endmodule

// File: tb/tb_ssp_ctrl.sv
// Directed self-checking bench for ssp_ctrl.
module tb_ssp_ctrl;
   import ssp_ctrl_pkg::*;

   localparam int NR_PENDING = 4;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              flush_i;
   logic              xBCFIE_i;
   logic              upd_valid_i;
   logic [2:0]        upd_trans_id_i;
   logic [XLEN-1:0]   upd_ssp_i;
   logic              upd_ready_o;
   logic              commit_valid_i;
   logic [2:0]        commit_trans_id_i;
   logic              commit_err_o;
   logic              csr_we_i;
   logic [XLEN-1:0]   csr_wdata_i;
   logic [XLEN-1:0]   ssp_o;
   logic [XLEN-1:0]   ssp_arch_o;
   logic [2:0]        pending_o;

   int checks = 0;
   int errors = 0;

   ssp_ctrl #(.NR_PENDING(NR_PENDING)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .flush_i           (flush_i),
      .xBCFIE_i          (xBCFIE_i),
      .upd_valid_i       (upd_valid_i),
      .upd_trans_id_i    (upd_trans_id_i),
      .upd_ssp_i         (upd_ssp_i),
      .upd_ready_o       (upd_ready_o),
      .commit_valid_i    (commit_valid_i),
      .commit_trans_id_i (commit_trans_id_i),
      .commit_err_o      (commit_err_o),
      .csr_we_i          (csr_we_i),
      .csr_wdata_i       (csr_wdata_i),
      .ssp_o             (ssp_o),
      .ssp_arch_o        (ssp_arch_o),
      .pending_o         (pending_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
      $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      upd_valid_i    = 1'b0;
      commit_valid_i = 1'b0;
      csr_we_i       = 1'b0;
      flush_i        = 1'b0;
   endtask

   task automatic enq(input logic [2:0] tag, input logic [63:0] val);
      upd_valid_i = 1'b1; upd_trans_id_i = tag; upd_ssp_i = val;
      tick();
      idle();
   endtask

   task automatic cmt(input logic [2:0] tag);
      commit_valid_i = 1'b1; commit_trans_id_i = tag;
      tick();
      idle();
   endtask

   initial begin
      rst_ni = 1'b0; xBCFIE_i = 1'b1;
      upd_trans_id_i = '0; upd_ssp_i = '0; commit_trans_id_i = '0; csr_wdata_i = '0;
      idle();
      repeat (3) tick();
      rst_ni = 1'b1;
      tick(); #1;

      chk("rst_ssp",     ssp_o, 64'h0);
      chk("rst_arch",    ssp_arch_o, 64'h0);
      chk("rst_ready",   {63'b0, upd_ready_o}, 64'h1);
      chk("rst_pending", {61'b0, pending_o}, 64'h0);
      chk("rst_err",     {63'b0, commit_err_o}, 64'h0);

      // Unmatched commit on an empty queue pulses the error for one cycle.
      cmt(3'd1);
      chk("empty_err",   {63'b0, commit_err_o}, 64'h1);
      tick();
      chk("err_clear",   {63'b0, commit_err_o}, 64'h0);

      // CSR write aligns and suppresses a same-cycle unmatched commit.
      csr_we_i = 1'b1; csr_wdata_i = 64'h8000_1007;
      commit_valid_i = 1'b1; commit_trans_id_i = 3'd0;
      tick(); idle();
      chk("csr_arch",    ssp_arch_o, 64'h8000_1000);
      chk("csr_ssp",     ssp_o, 64'h8000_1000);
      chk("csr_no_err",  {63'b0, commit_err_o}, 64'h0);

      enq(3'd2, 64'h8000_1010);
      chk("enq_ssp",     ssp_o, 64'h8000_1010);
      chk("enq_arch",    ssp_arch_o, 64'h8000_1000);
      chk("enq_pending", {61'b0, pending_o}, 64'h1);
      cmt(3'd2);
      chk("cmt_arch",    ssp_arch_o, 64'h8000_1010);
      chk("cmt_pending", {61'b0, pending_o}, 64'h0);

      // Fill the queue.
      for (int i = 0; i < 4; i++) enq(3'(i), 64'h100 + 64'(8 * i));
      chk("full_ready",  {63'b0, upd_ready_o}, 64'h0);
      chk("full_pend",   {61'b0, pending_o}, 64'h4);
      chk("full_ssp",    ssp_o, 64'h118);
      enq(3'd4, 64'h120);
      chk("over_pend",   {61'b0, pending_o}, 64'h4);
      chk("over_ssp",    ssp_o, 64'h118);

      // Commit while full with an enqueue attempt: only the commit lands.
      commit_valid_i = 1'b1; commit_trans_id_i = 3'd0;
      upd_valid_i = 1'b1; upd_trans_id_i = 3'd4; upd_ssp_i = 64'h120;
      tick(); idle();
      chk("fc_pend",     {61'b0, pending_o}, 64'h3);
      chk("fc_arch",     ssp_arch_o, 64'h100);
      chk("fc_ssp",      ssp_o, 64'h118);
      for (int i = 1; i < 4; i++) begin
         cmt(3'(i));
         chk("drain_arch", ssp_arch_o, 64'h100 + 64'(8 * i));
      end
      chk("drain_pend",  {61'b0, pending_o}, 64'h0);

      // Six more round trips wrap both pointers.
      for (int i = 0; i < 6; i++) begin
         enq(3'(i), 64'h300 + 64'(8 * i));
         cmt(3'(i));
         chk("wrap_arch", ssp_arch_o, 64'h300 + 64'(8 * i));
      end

      // Tag mismatch at head.
      enq(3'd5, 64'h200);
      enq(3'd6, 64'h208);
      cmt(3'd6);
      chk("mm_err",      {63'b0, commit_err_o}, 64'h1);
      chk("mm_arch",     ssp_arch_o, 64'h328);
      chk("mm_pend",     {61'b0, pending_o}, 64'h2);
      tick();
      chk("mm_err_off",  {63'b0, commit_err_o}, 64'h0);
      cmt(3'd5);
      chk("mm_fix_arch", ssp_arch_o, 64'h200);
      chk("mm_fix_pend", {61'b0, pending_o}, 64'h1);

      // Flush with head commit and enqueue in the same cycle.
      enq(3'd7, 64'h210);
      flush_i = 1'b1;
      commit_valid_i = 1'b1; commit_trans_id_i = 3'd6;
      upd_valid_i = 1'b1; upd_trans_id_i = 3'd0; upd_ssp_i = 64'h400;
      tick(); idle();
      chk("fl_arch",     ssp_arch_o, 64'h208);
      chk("fl_pend",     {61'b0, pending_o}, 64'h0);
      chk("fl_ssp",      ssp_o, 64'h208);

      // Simultaneous enqueue and commit mid-queue; unaligned update value.
      enq(3'd1, 64'h500);
      upd_valid_i = 1'b1; upd_trans_id_i = 3'd2; upd_ssp_i = 64'h50f;
      commit_valid_i = 1'b1; commit_trans_id_i = 3'd1;
      tick(); idle();
      chk("ec_pend",     {61'b0, pending_o}, 64'h1);
      chk("ec_arch",     ssp_arch_o, 64'h500);
      chk("ec_ssp",      ssp_o, 64'h508);
      cmt(3'd2);
      chk("ec_arch2",    ssp_arch_o, 64'h508);

      // CFI disabled: updates dropped, ssp_o forced low.
      xBCFIE_i = 1'b0; upd_valid_i = 1'b1; upd_trans_id_i = 3'd3; upd_ssp_i = 64'h600;
      #1;
      chk("dis_ssp",     ssp_o, 64'h0);
      tick(); idle();
      xBCFIE_i = 1'b1; #1;
      chk("dis_pend",    {61'b0, pending_o}, 64'h0);
      chk("en_ssp",      ssp_o, 64'h508);

      // Asynchronous reset in the middle of a cycle with an entry pending.
      enq(3'd4, 64'h700);
      chk("pre_rst_pend", {61'b0, pending_o}, 64'h1);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_ssp",    ssp_o, 64'h0);
      chk("arst_arch",   ssp_arch_o, 64'h0);
      chk("arst_pend",   {61'b0, pending_o}, 64'h0);
      chk("arst_ready",  {63'b0, upd_ready_o}, 64'h1);
      tick();
      rst_ni = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
